paddle_quadrature_decoder: RTL and testbench



---
 rtl/qdec_pkg.sv | 42 ++++
 rtl/qdec_glitch_filter.sv | 52 +++++
 rtl/paddle_quadrature_decoder.sv | 132 +++++++++++++
 tb/tb_paddle_quadrature_decoder.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/qdec_pkg.sv
// qdec_pkg: shared definitions for the paddle quadrature decoder.
//   phase_e     - Gray-coded {A,B} phase values PH_00, PH_01, PH_11, PH_10
//   dir_e       - decoded transition class DIR_NONE, DIR_UP, DIR_DOWN, DIR_ERR
//   step_phase  - forward/reverse neighbour of a phase
//   classify    - classifies a prev->cur phase transition
package qdec_pkg;

  typedef enum logic [1:0] {
    PH_00 = 2'b00,
    PH_01 = 2'b01,
    PH_11 = 2'b11,
    PH_10 = 2'b10
  } phase_e;

  typedef enum logic [1:0] {
    DIR_NONE = 2'd0,
    DIR_UP   = 2'd1,
    DIR_DOWN = 2'd2,
    DIR_ERR  = 2'd3
  } dir_e;

  // Forward order is 00 -> 01 -> 11 -> 10 -> 00; reverse is the opposite.
  function automatic logic [1:0] step_phase(input logic [1:0] ph, input logic fwd);
    logic [1:0] nxt;
    logic [1:0] prv;
    case (ph)
      PH_00:   begin nxt = PH_01; prv = PH_10; end
      PH_01:   begin nxt = PH_11; prv = PH_00; end
      PH_11:   begin nxt = PH_10; prv = PH_01; end
      default: begin nxt = PH_00; prv = PH_11; end
    endcase
    return fwd ? nxt : prv;
  endfunction

  function automatic dir_e classify(input logic [1:0] prev, input logic [1:0] cur);
    if (cur == prev)                       return DIR_NONE;
    else if (cur == step_phase(prev, 1'b1)) return DIR_UP;
    else if (cur == step_phase(prev, 1'b0)) return DIR_DOWN;
    else                                   return DIR_ERR;
  endfunction

endpackage

// File: rtl/qdec_glitch_filter.sv
// qdec_glitch_filter: 2-flop synchronizer followed by a stable-count filter.
//   clk  - system clock
//   rst  - synchronous active-high reset (clears synchronizer, filter, count)
//   raw  - asynchronous input channel
//   filt - filtered channel; follows the synchronized value only after it has
//          differed from filt for DEBOUNCE_CYCLES consecutive cycles
module qdec_glitch_filter #(
  parameter int unsigned DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic filt
);

  logic       sync1_q, sync1_d;
  logic       sync2_q, sync2_d;
  logic       filt_q,  filt_d;
  logic [7:0] cnt_q,   cnt_d;

  always_comb begin
    sync1_d = raw;
    sync2_d = sync1_q;
    filt_d  = filt_q;
    cnt_d   = '0;
    if (sync2_q != filt_q) begin
      // cnt_q holds the number of earlier consecutive differing cycles.
      if (cnt_q == 8'(DEBOUNCE_CYCLES - 1)) begin
        filt_d = sync2_q;
      end else begin
        cnt_d = cnt_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      filt_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      filt_q  <= filt_d;
      cnt_q   <= cnt_d;
    end
  end

  assign filt = filt_q;

endmodule

// File: rtl/paddle_quadrature_decoder.sv
// paddle_quadrature_decoder: quadrature encoder to bounded paddle position.
//   CLOCK, Reset          - clock, synchronous active-high reset
//   QuadA, QuadB          - raw asynchronous encoder channels
//   BeginPos, EndPos      - unsigned position limits
//   Load, LoadValue       - parallel load (clamped into the limits)
//   Position              - registered saturating position
//   StepUp, StepDown      - one-cycle decoded step pulses
//   AtLimit               - Position at either limit, or limits inverted
//   Error                 - one-cycle pulse when both filtered bits change
// Optional macro QDEC_DIV4_EN: one step per full detent (4 transitions).
module paddle_quadrature_decoder
  import qdec_pkg::*;
#(
  parameter int unsigned length          = 10,
  parameter int unsigned DEBOUNCE_CYCLES = 16
) (
  input  logic              CLOCK,
  input  logic              Reset,
  input  logic              QuadA,
  input  logic              QuadB,
  input  logic [length-1:0] BeginPos,
  input  logic [length-1:0] EndPos,
  input  logic              Load,
  input  logic [length-1:0] LoadValue,
  output logic [length-1:0] Position,
  output logic              StepUp,
  output logic              StepDown,
  output logic              AtLimit,
  output logic              Error
);

  logic filt_a, filt_b;

  qdec_glitch_filter #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_filt_a (
    .clk(CLOCK), .rst(Reset), .raw(QuadA), .filt(filt_a)
  );

  qdec_glitch_filter #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_filt_b (
    .clk(CLOCK), .rst(Reset), .raw(QuadB), .filt(filt_b)
  );

  logic [1:0]        prev_q,      prev_d;
  logic              primed_q,    primed_d;
  logic [length-1:0] pos_q,       pos_d;
  logic              step_up_q,   step_up_d;
  logic              step_down_q, step_down_d;
  logic              error_q,     error_d;
  dir_e              dir;
  logic              limits_bad;
`ifdef QDEC_DIV4_EN
  logic signed [2:0] sub_q,       sub_d;
`endif

  assign limits_bad = (BeginPos > EndPos);

  always_comb begin
    prev_d      = {filt_a, filt_b};
    primed_d    = 1'b1;
    dir         = DIR_NONE;
    step_up_d   = 1'b0;
    step_down_d = 1'b0;
    // The first cycle after reset only captures the pair.
    if (primed_q) dir = classify(prev_q, {filt_a, filt_b});
    error_d = (dir == DIR_ERR);
`ifdef QDEC_DIV4_EN
    // Sub-count holds -3..+3; the fourth like transition fires and rewinds.
    sub_d = sub_q;
    if (dir == DIR_UP) begin
      if (sub_q == 3'sd3) begin
        step_up_d = 1'b1;
        sub_d     = '0;
      end else begin
        sub_d = sub_q + 3'sd1;
      end
    end else if (dir == DIR_DOWN) begin
      if (sub_q == -3'sd3) begin
        step_down_d = 1'b1;
        sub_d       = '0;
      end else begin
        sub_d = sub_q - 3'sd1;
      end
    end
    if (Load) sub_d = '0;
`else
    step_up_d   = (dir == DIR_UP);
    step_down_d = (dir == DIR_DOWN);
`endif
    pos_d = pos_q;
    if (limits_bad) begin
      pos_d = BeginPos;
    end else if (Load) begin
      if (LoadValue < BeginPos)    pos_d = BeginPos;
      else if (LoadValue > EndPos) pos_d = EndPos;
      else                         pos_d = LoadValue;
    end else if (step_up_d && (pos_q < EndPos)) begin
      pos_d = pos_q + length'(1);
    end else if (step_down_d && (pos_q > BeginPos)) begin
      pos_d = pos_q - length'(1);
    end
  end

  always_ff @(posedge CLOCK) begin
    if (Reset) begin
      prev_q      <= '0;
      primed_q    <= 1'b0;
      pos_q       <= BeginPos;
      step_up_q   <= 1'b0;
      step_down_q <= 1'b0;
      error_q     <= 1'b0;
`ifdef QDEC_DIV4_EN
      sub_q       <= '0;
`endif
    end else begin
      prev_q      <= prev_d;
      primed_q    <= primed_d;
      pos_q       <= pos_d;
      step_up_q   <= step_up_d;
      step_down_q <= step_down_d;
      error_q     <= error_d;
`ifdef QDEC_DIV4_EN
      sub_q       <= sub_d;
`endif
    end
  end

  assign Position = pos_q;
  assign StepUp   = step_up_q;
  assign StepDown = step_down_q;
  assign Error    = error_q;
  assign AtLimit  = (pos_q == BeginPos) || (pos_q == EndPos) || limits_bad;

endmodule

// File: tb/tb_paddle_quadrature_decoder.sv
// Bench for paddle_quadrature_decoder (length=10, DEBOUNCE_CYCLES=4).
// Honours QDEC_DIV4_EN in both the reference model and the directed steps.
module tb_paddle_quadrature_decoder;

  localparam int W = 10;
  localparam int D = 4;

  logic         CLOCK = 1'b0;
  logic         Reset;
  logic         QuadA, QuadB;
  logic [W-1:0] BeginPos, EndPos, LoadValue;
  logic         Load;
  logic [W-1:0] Position;
  logic         StepUp, StepDown, AtLimit, Error;

  paddle_quadrature_decoder #(.length(W), .DEBOUNCE_CYCLES(D)) dut (
    .CLOCK(CLOCK), .Reset(Reset), .QuadA(QuadA), .QuadB(QuadB),
    .BeginPos(BeginPos), .EndPos(EndPos), .Load(Load), .LoadValue(LoadValue),
    .Position(Position), .StepUp(StepUp), .StepDown(StepDown),
    .AtLimit(AtLimit), .Error(Error)
  );

  always #5 CLOCK = ~CLOCK;

  int checks = 0;
  int errors = 0;
  int ups = 0, dns = 0, errs = 0;

  // Reference model: sliding window of the last D synchronized samples per
  // channel; the filtered bit flips when every sample in the window differs.
  bit [D-1:0] win_a, win_b;
  bit         s1a, s2a, s1b, s2b, fa, fb;
  bit [1:0]   m_prev;
  bit         m_primed;
  int         m_pos, m_sub;
  bit         m_up, m_dn, m_err;

  function automatic int ph_idx(input bit [1:0] p);
    case (p)
      2'b00:   return 0;
      2'b01:   return 1;
      2'b11:   return 2;
      default: return 3;
    endcase
  endfunction

  task automatic model_step();
    bit [1:0] cur;
    bit       nfa, nfb;
    int       mv, diff;
    if (Reset) begin
      win_a = '0; win_b = '0;
      s1a = 0; s2a = 0; s1b = 0; s2b = 0; fa = 0; fb = 0;
      m_prev = 2'b00; m_primed = 0; m_sub = 0;
      m_up = 0; m_dn = 0; m_err = 0;
      m_pos = int'(BeginPos);
      return;
    end
    win_a = {win_a[D-2:0], s2a};
    win_b = {win_b[D-2:0], s2b};
    nfa = (win_a == (fa ? {D{1'b0}} : {D{1'b1}})) ? !fa : fa;
    nfb = (win_b == (fb ? {D{1'b0}} : {D{1'b1}})) ? !fb : fb;
    cur = {fa, fb};
    mv = 0; m_err = 0; m_up = 0; m_dn = 0;
    if (!m_primed) begin
      m_primed = 1;
    end else begin
      diff = (ph_idx(cur) - ph_idx(m_prev) + 4) % 4;
      if (diff == 1)      mv = 1;
      else if (diff == 3) mv = -1;
      else if (diff == 2) m_err = 1;
    end
    m_prev = cur;
`ifdef QDEC_DIV4_EN
    m_sub += mv;
    if (m_sub == 4)  begin m_up = 1; m_sub = 0; end
    if (m_sub == -4) begin m_dn = 1; m_sub = 0; end
    if (Load) m_sub = 0;
`else
    m_up = (mv == 1);
    m_dn = (mv == -1);
`endif
    if (BeginPos > EndPos)                      m_pos = int'(BeginPos);
    else if (Load) begin
      if (LoadValue < BeginPos)                 m_pos = int'(BeginPos);
      else if (LoadValue > EndPos)              m_pos = int'(EndPos);
      else                                      m_pos = int'(LoadValue);
    end
    else if (m_up && m_pos < int'(EndPos))      m_pos = m_pos + 1;
    else if (m_dn && m_pos > int'(BeginPos))    m_pos = m_pos - 1;
    s2a = s1a; s1a = QuadA; s2b = s1b; s1b = QuadB;
    fa = nfa; fb = nfb;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Inputs are set before calling; outputs are checked on the following negedge.
  task automatic tick();
    bit lim;
    model_step();
    @(posedge CLOCK);
    @(negedge CLOCK);
    lim = (m_pos == int'(BeginPos)) || (m_pos == int'(EndPos)) || (BeginPos > EndPos);
    chk("position", 32'(Position), 32'(m_pos));
    chk("step_up",  32'(StepUp),   32'(m_up));
    chk("step_down",32'(StepDown), 32'(m_dn));
    chk("error",    32'(Error),    32'(m_err));
    chk("at_limit", 32'(AtLimit),  32'(lim));
    if (StepUp)   ups++;
    if (StepDown) dns++;
    if (Error)    errs++;
  endtask

  task automatic hold(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, seg, k, b;
    logic [W-1:0] p0;
    bit [1:0] fwd [4];
    fwd[0] = 2'b01; fwd[1] = 2'b11; fwd[2] = 2'b10; fwd[3] = 2'b00;

    Reset = 1; QuadA = 0; QuadB = 0; Load = 0; LoadValue = '0;
    BeginPos = 10'd0; EndPos = 10'd100;
    @(negedge CLOCK);
    hold(3);
    chk("reset_pos",    32'(Position), 32'd0);
    chk("reset_limit",  32'(AtLimit),  32'd1);
    Reset = 0;
    hold(5);

`ifndef QDEC_DIV4_EN
    // Forward sequence with latency measurement on the first edge.
    ups = 0; dns = 0;
    {QuadA, QuadB} = fwd[0];
    lat = 0;
    do begin tick(); lat++; end while (!StepUp && lat < 20);
    chk("latency", 32'(lat), 32'd7);
    hold(10 - lat);
    for (int i = 1; i < 4; i++) begin {QuadA, QuadB} = fwd[i]; hold(10); end
    chk("fwd_pulses", 32'(ups), 32'd4);
    chk("fwd_pos",    32'(Position), 32'd4);

    // Short glitch is swallowed.
    ups = 0; dns = 0;
    QuadA = 1; hold(2); QuadA = 0; hold(12);
    chk("glitch_pulses", 32'(ups + dns), 32'd0);
    chk("glitch_pos",    32'(Position), 32'd4);

    // Load near the top, then saturate.
    Load = 1; LoadValue = 10'd99; tick(); Load = 0;
    chk("load_pos", 32'(Position), 32'd99);
    ups = 0;
    for (int i = 0; i < 3; i++) begin {QuadA, QuadB} = fwd[i]; hold(10); end
    chk("sat_pulses", 32'(ups), 32'd3);
    chk("sat_pos",    32'(Position), 32'd100);
    chk("sat_limit",  32'(AtLimit), 32'd1);

    // Simultaneous change of both channels.
    {QuadA, QuadB} = 2'b00; hold(10);
    ups = 0; dns = 0; errs = 0;
    {QuadA, QuadB} = 2'b11; hold(12);
    chk("err_pulses", 32'(errs), 32'd1);
    chk("err_steps",  32'(ups + dns), 32'd0);
    chk("err_pos",    32'(Position), 32'd100);

    // Out-of-range load coinciding with a reverse step.
    QuadA = 0; hold(6);
    Load = 1; LoadValue = 10'd200; tick(); Load = 0;
    chk("ldstep_down", 32'(StepDown), 32'd1);
    chk("ldstep_pos",  32'(Position), 32'd100);
    hold(5);
`else
    // Detent mode: 3 forward + 1 reverse gives nothing, 4 forward gives one step.
    ups = 0; dns = 0;
    p0 = Position;
    for (int i = 0; i < 3; i++) begin {QuadA, QuadB} = fwd[i]; hold(10); end
    {QuadA, QuadB} = 2'b11; hold(10);
    chk("div4_none", 32'(ups + dns), 32'd0);
    {QuadA, QuadB} = 2'b10; hold(10);
    {QuadA, QuadB} = 2'b00; hold(10);
    {QuadA, QuadB} = 2'b01; hold(10);
    {QuadA, QuadB} = 2'b11; hold(10);
    chk("div4_ups", 32'(ups), 32'd1);
    chk("div4_dns", 32'(dns), 32'd0);
    chk("div4_pos", 32'(Position), 32'(p0) + 32'd1);
`endif

    // Randomized segments against the reference model.
    for (seg = 0; seg < 150; seg++) begin
      k = $urandom_range(0, 19);
      if (k == 0) begin
        Reset = 1; hold($urandom_range(1, 2)); Reset = 0;
      end else if (k < 3) begin
        b = $urandom_range(0, 20);
        BeginPos = 10'(b);
        if ($urandom_range(0, 4) == 0 && b > 0) EndPos = 10'(b - 1);
        else                                     EndPos = 10'(b + $urandom_range(0, 15));
        hold(1);
      end else begin
        {QuadA, QuadB} = 2'($urandom_range(0, 3));
        for (int i = 0; i < $urandom_range(1, 12); i++) begin
          Load = ($urandom_range(0, 15) == 0);
          LoadValue = 10'($urandom_range(0, 40));
          tick();
        end
        Load = 0;
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
